// File: rtl/gaus_mem_pkg.sv
// ---------------------------------------------------------------------------
// gaus_mem_pkg
// Shared definitions for the Gaussian stage memory-side blocks (read line
// buffer and write block): pixel/word geometry, the frame state encoding and
// a helper that drops a pixel into its byte lane of a packed word.
// ---------------------------------------------------------------------------
package gaus_mem_pkg;

    localparam int PIXEL_WIDTH  = 8;
    localparam int WORD_WIDTH   = 64;
    localparam int PIX_PER_WORD = 8;

    // Frame state encoding, kept as plain constants so older tools that
    // share this package can decode the state register directly.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Little-endian packing: slot 0 lands in bits [7:0], slot 7 in [63:56].
    function automatic logic [WORD_WIDTH-1:0] insert_pixel(
        input logic [WORD_WIDTH-1:0]  word,
        input logic [PIXEL_WIDTH-1:0] pixel,
        input logic [2:0]             slot
    );
        logic [WORD_WIDTH-1:0] result;
        result = word;
        result[{slot, 3'b000} +: PIXEL_WIDTH] = pixel;
        return result;
    endfunction

endpackage

// File: rtl/buffer_write_block_word_fifo.sv
// ---------------------------------------------------------------------------
// word_fifo
// Synchronous DEPTH x WIDTH FIFO holding packed words between the pixel
// packer and the memory write handshake. Push and pop may occur on the same
// edge. The head entry is presented combinationally on head.
//   clk, reset       : clock and asynchronous active-high reset (empties FIFO)
//   push, push_data  : write one entry (caller guarantees !full)
//   pop              : discard the head entry (caller guarantees !empty)
//   head             : current head entry, valid while !empty
//   full, empty      : occupancy flags
// ---------------------------------------------------------------------------
module word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/buffer_write_block.sv
// ---------------------------------------------------------------------------
// buffer_write_block
// Packs a stream of 8-bit filtered pixels into 64-bit little-endian words,
// queues them in a BEATS-deep FIFO and writes them to memory over a req/ack
// handshake at word addresses STARTADDRESS..ENDADDRESS.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : pulse, arms a frame from IDLE or DONE
//   pixelIn/Valid/Ready   : pixel stream handshake
//   flush                 : level, ends the frame early (zero-pads partial word)
//   writeReq/Addr/Data    : memory write request, held until writeAck
//   writeAck              : memory accepted the presented word
//   done                  : high once the frame has fully drained
// ---------------------------------------------------------------------------
module buffer_write_block
    import gaus_mem_pkg::*;
#(
    parameter int unsigned STARTADDRESS = 0,
    parameter int unsigned ENDADDRESS   = 2097151,
    parameter int          BEATS        = 4,
    parameter int          PIXW         = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PIXEL_WIDTH-1:0] pixelIn,
    input  logic                   pixelValid,
    output logic                   pixelReady,
    input  logic                   flush,
    output logic                   writeReq,
    output logic [PIXW-1:0]        writeAddr,
    output logic [WORD_WIDTH-1:0]  writeData,
    input  logic                   writeAck,
    output logic                   done
);

    localparam logic [PIXW-1:0] START_ADDR  = PIXW'(STARTADDRESS);
    localparam logic [PIXW-1:0] END_ADDR    = PIXW'(ENDADDRESS);
    localparam logic [PIXW:0]   TOTAL_WORDS = (PIXW + 1)'(ENDADDRESS - STARTADDRESS + 1);

    logic [1:0]            state;
    logic [2:0]            pack_count;
    logic [WORD_WIDTH-1:0] pack_data;
    logic [PIXW:0]         words_pushed;

    logic                  in_run;
    logic                  accept;
    logic                  start_frame;
    logic [WORD_WIDTH-1:0] merged_data;
    logic                  word_complete;
    logic                  flush_partial;
    logic                  flush_empty;
    logic                  budget_hit;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [WORD_WIDTH-1:0] fifo_head;

    word_fifo #(
        .DEPTH (BEATS),
        .WIDTH (WORD_WIDTH)
    ) u_word_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (merged_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pixel acceptance is conservative: a word-completing pixel needs FIFO
    // space now, ignoring any pop on the same edge. A flush blocked by a full
    // FIFO also stalls the stream so the partial word cannot change under it.
    always_comb begin
        in_run        = (state == ST_RUN);
        pixelReady    = in_run && !((pack_count == 3'd7) && fifo_full)
                               && !(flush && fifo_full);
        accept        = pixelValid && pixelReady;
        start_frame   = start && ((state == ST_IDLE) || (state == ST_DONE));
        merged_data   = accept ? insert_pixel(pack_data, pixelIn, pack_count) : pack_data;
        word_complete = accept && (pack_count == 3'd7);
        // A pixel arriving together with flush is folded in before flushing.
        flush_partial = in_run && flush && !word_complete
                        && ((pack_count != 3'd0) || accept) && !fifo_full;
        flush_empty   = in_run && flush && !word_complete
                        && (pack_count == 3'd0) && !accept;
        fifo_push     = word_complete || flush_partial;
        budget_hit    = fifo_push && ((words_pushed + 1'b1) == TOTAL_WORDS);
        fifo_pop      = !fifo_empty && (!writeReq || writeAck);
        done          = (state == ST_DONE);
    end

    // Frame control and pixel packing. The pack register is cleared whenever
    // a word is pushed so a later partial word is zero-padded for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            pack_count   <= '0;
            pack_data    <= '0;
            words_pushed <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_frame) begin
                        state        <= ST_RUN;
                        pack_count   <= '0;
                        pack_data    <= '0;
                        words_pushed <= '0;
                    end
                end
                ST_RUN: begin
                    if (fifo_push) begin
                        pack_count   <= '0;
                        pack_data    <= '0;
                        words_pushed <= words_pushed + 1'b1;
                        if (budget_hit || flush) begin
                            state <= ST_DRAIN;
                        end
                    end else if (flush_empty) begin
                        state <= ST_DRAIN;
                    end else if (accept) begin
                        pack_count <= pack_count + 3'd1;
                        pack_data  <= merged_data;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !writeReq) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write handshake. The FIFO head is loaded whenever the output register
    // is free or being acked, so queued words go out back-to-back. The
    // address saturates at ENDADDRESS; the word budget prevents any write
    // beyond it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            writeReq  <= 1'b0;
            writeAddr <= START_ADDR;
            writeData <= '0;
        end else begin
            if (start_frame) begin
                writeAddr <= START_ADDR;
            end else if (writeReq && writeAck && (writeAddr != END_ADDR)) begin
                writeAddr <= writeAddr + 1'b1;
            end

            if (fifo_pop) begin
                writeReq  <= 1'b1;
                writeData <= fifo_head;
            end else if (writeAck) begin
                writeReq <= 1'b0;
            end
        end
    end

endmodule
